// File: rtl/cordic_arb_pkg.sv
// rtl/cordic_arb_pkg.sv - shared types and constants for the cordic atan arbiter
package cordic_arb_pkg;

    localparam int STAT_W = 16;
    // Tag index sized for the largest supported requester count (8)
    localparam int IDX_W  = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search starting after last
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    // Walk from farthest to nearest so the closest requester after last wins
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                gnt = '0;
                gnt[(int'(last) + i) % N] = 1'b1;
                idx = $clog2(N)'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/cordic_atan_arb.sv
// rtl/cordic_atan_arb.sv - round-robin sharing of one pipelined atan core; optional stats via CORDIC_ARB_STATS_EN
module cordic_atan_arb
    import cordic_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int INPUT_ACC  = 10,
    parameter int OUTPUT_ACC = 10,
    parameter int CORDIC_LAT = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*INPUT_ACC-1:0]  req_re_i,
    input  logic [N_REQ*INPUT_ACC-1:0]  req_im_i,
    output logic [N_REQ-1:0]            rsp_valid_o,
    output logic [OUTPUT_ACC-1:0]       rsp_atan_o,
    output logic [INPUT_ACC-1:0]        core_re_o,
    output logic [INPUT_ACC-1:0]        core_im_o,
    input  logic [OUTPUT_ACC-1:0]       core_atan_i,
    input  logic                        flush_i,
`ifdef CORDIC_ARB_STATS_EN
    input  logic                        stat_clr_i,
    output logic [N_REQ*STAT_W-1:0]     stat_grants_o,
    output logic [31:0]                 stat_busy_o,
`endif
    output logic                        idle_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(CORDIC_LAT + 2);

    arb_state_e       state, state_nx;
    logic [IW-1:0]    last, gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             accept;
    logic [CW-1:0]    inflight;
    tag_t             in_tag;
    tag_t             tag_pipe [CORDIC_LAT];
    tag_t             tail;

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req  (req_valid_i),
        .last (last),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    assign req_ready_o = (state == RUN) ? gnt : '0;
    assign accept      = |(req_ready_o & req_valid_i);
    assign tail        = tag_pipe[CORDIC_LAT-1];
    assign idle_o      = (state == HALT);

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (flush_i) state_nx = DRAIN;
            DRAIN:   if (inflight == '0) state_nx = HALT;
                     else if (!flush_i) state_nx = RUN;
            HALT:    if (!flush_i) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // in_tag travels with core_re_o/core_im_o, so the tail lines up with core_atan_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            last      <= IW'(N_REQ - 1);
            core_re_o <= '0;
            core_im_o <= '0;
            in_tag    <= '0;
        end else begin
            state <= state_nx;
            if (accept) last <= gnt_idx;
            core_re_o    <= accept ? req_re_i[int'(gnt_idx)*INPUT_ACC +: INPUT_ACC] : '0;
            core_im_o    <= accept ? req_im_i[int'(gnt_idx)*INPUT_ACC +: INPUT_ACC] : '0;
            in_tag.valid <= accept;
            in_tag.idx   <= IDX_W'(gnt_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CORDIC_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= in_tag;
            for (int i = 1; i < CORDIC_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (accept && !tail.valid) begin
            inflight <= inflight + 1'b1;
        end else if (!accept && tail.valid) begin
            inflight <= inflight - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_o <= '0;
            rsp_atan_o  <= '0;
        end else begin
            rsp_valid_o <= tail.valid ? (N_REQ'(1) << tail.idx) : '0;
            if (tail.valid) rsp_atan_o <= core_atan_i;
        end
    end

`ifdef CORDIC_ARB_STATS_EN
    logic [STAT_W-1:0] grants [N_REQ];
    logic [31:0]       busy_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) grants[i] <= '0;
            busy_cnt <= '0;
        end else if (stat_clr_i) begin
            for (int i = 0; i < N_REQ; i++) grants[i] <= '0;
            busy_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if (req_ready_o[i] && req_valid_i[i] && grants[i] != '1)
                    grants[i] <= grants[i] + 1'b1;
            if (inflight != '0 && busy_cnt != '1) busy_cnt <= busy_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_grants_o[g*STAT_W +: STAT_W] = grants[g];
    end
    assign stat_busy_o = busy_cnt;
`endif

endmodule

// File: tb/tb_cordic_atan_arb.sv
// tb/tb_cordic_atan_arb.sv - directed self-checking bench with a delay-line core model and response scoreboard
module tb_cordic_atan_arb;

    localparam int N   = 4;
    localparam int IA  = 10;
    localparam int OA  = 10;
    localparam int LAT = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*IA-1:0] req_re, req_im;
    logic [N-1:0]    rsp_valid;
    logic [OA-1:0]   rsp_atan;
    logic [IA-1:0]   core_re, core_im;
    logic [OA-1:0]   core_atan;
    logic            flush;
    logic            idle;
`ifdef CORDIC_ARB_STATS_EN
    logic            stat_clr;
    logic [N*16-1:0] stat_grants;
    logic [31:0]     stat_busy;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rsp_seen = 0;

    typedef struct {
        logic [N-1:0]  oh;
        logic [OA-1:0] atan;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    int            gnt_log[$];
    logic [OA-1:0] mdl [LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_atan_arb #(.N_REQ(N), .INPUT_ACC(IA), .OUTPUT_ACC(OA), .CORDIC_LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_re_i    (req_re),
        .req_im_i    (req_im),
        .rsp_valid_o (rsp_valid),
        .rsp_atan_o  (rsp_atan),
        .core_re_o   (core_re),
        .core_im_o   (core_im),
        .core_atan_i (core_atan),
        .flush_i     (flush),
`ifdef CORDIC_ARB_STATS_EN
        .stat_clr_i    (stat_clr),
        .stat_grants_o (stat_grants),
        .stat_busy_o   (stat_busy),
`endif
        .idle_o      (idle)
    );

    // Exact angles (scaled by 128) for the directed sample set
    function automatic logic [OA-1:0] atan_ref(input logic signed [IA-1:0] re, input logic signed [IA-1:0] im);
        if (im == 0)        return OA'(0);
        else if (re == im)  return OA'(100);
        else if (re == 0)   return OA'(201);
        else if (re == -im) return OA'(-100);
        else                return OA'(341);
    endfunction

    always @(posedge clk) begin
        mdl[0] <= atan_ref(core_re, core_im);
        for (int i = 1; i < LAT; i++) mdl[i] <= mdl[i-1];
    end
    assign core_atan = mdl[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_sample(input int i, input int re, input int im);
        req_re[i*IA +: IA] = IA'(re);
        req_im[i*IA +: IA] = IA'(im);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Scoreboard: accept at cycle c must come back at cycle c+LAT+2 to the same requester
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) check("ready_onehot", $onehot(req_ready), 1);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.oh   = N'(1) << i;
                    e.atan = atan_ref(req_re[i*IA +: IA], req_im[i*IA +: IA]);
                    e.due  = cyc + LAT + 2;
                    exp_q.push_back(e);
                    gnt_log.push_back(i);
                end
            end
            if (rsp_valid != '0) begin
                rsp_seen++;
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_dest", rsp_valid, e.oh);
                    check("rsp_atan", rsp_atan, e.atan);
                    check("rsp_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        int n;
        int base;
        req_valid = '0;
        req_re    = '0;
        req_im    = '0;
        flush     = 1'b0;
`ifdef CORDIC_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_atan", rsp_atan, 0);
        check("rst_core_re", core_re, 0);
        check("rst_core_im", core_im, 0);
        check("rst_idle", idle, 0);
        rst_n = 1'b1;

        // All four active: rotation 0,1,2,3 twice, distinct results per requester
        set_sample(0, 256, 0);
        set_sample(1, 256, 256);
        set_sample(2, 0, 256);
        set_sample(3, 256, -256);
        gnt_log.delete();
        req_valid = 4'hF;
        repeat (8) @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain();
        check("rot_count", gnt_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) check("rot_order", gnt_log[i], i % 4);

        // Single requester latency
        req_valid = 4'b0001;
        #1;
        check("single_ready", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid != '0) break;
        end
        check("single_latency", n, LAT + 1);
        check("single_rsp_valid", rsp_valid, 4'b0001);
        check("single_rsp_atan", rsp_atan, 0);
        wait_drain();

        // Requesters 1 and 3 streaming
        gnt_log.delete();
        base = rsp_seen;
        req_valid = 4'b1010;
        repeat (8) @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain();
        check("stream_rsp_count", rsp_seen - base, 8);
        check("stream_count", gnt_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) check("stream_order", gnt_log[i], (i % 2) ? 3 : 1);

        // Flush with 5 samples in flight
        req_valid = 4'b0001;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0101;
        check("flush_ready", req_ready, 0);
        check("flush_idle_early", idle, 0);
        n = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (rsp_valid != '0) n++;
            if (n == 5) break;
        end
        check("flush_rsp_count", n, 5);
        check("idle_at_last_rsp", idle, 0);
        @(posedge clk); #1;
        check("idle_after_last_rsp", idle, 1);
        check("halt_ready", req_ready, 0);
        flush = 1'b0;
        @(posedge clk); #1;
        check("resume_ready", req_ready, 4'b0100);
        check("resume_idle", idle, 0);
        @(posedge clk); #1;
        req_valid = '0;
        wait_drain();

        // Reset with 6 samples in flight
        req_valid = 4'hF;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_atan", rsp_atan, 0);
        check("mid_rst_core_re", core_re, 0);
        check("mid_rst_core_im", core_im, 0);
        check("mid_rst_idle", idle, 0);
        check("mid_rst_ready", req_ready, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        base = rsp_seen;
        repeat (30) @(posedge clk);
        #1;
        check("no_rsp_after_rst", rsp_seen - base, 0);
        req_valid = 4'b1001;
        #1;
        check("first_gnt_after_rst", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        wait_drain();

`ifdef CORDIC_ARB_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        req_valid = 4'b0100;
        repeat (10) @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain();
        check("stat_grants2", stat_grants[2*16 +: 16], 10);
        check("stat_grants0", stat_grants[0 +: 16], 0);
        check("stat_busy_nonzero", stat_busy != 0, 1);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("stat_clr_grants", stat_grants, 0);
        check("stat_clr_busy", stat_busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
